// File: rtl/regfile_pkg.sv
// Shared widths and helpers for the parametrised register file with busy scoreboard.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  // Helpers operate on the widest supported shapes; callers cast in and out.
  localparam int unsigned XLEN_MAX  = 512;
  localparam int unsigned STRB_MAX  = XLEN_MAX / 8;
  localparam int unsigned NREGS_MAX = 1024;

  function automatic logic [XLEN_MAX-1:0] strb_merge(
    input logic [XLEN_MAX-1:0] oldVal,
    input logic [XLEN_MAX-1:0] newVal,
    input logic [STRB_MAX-1:0] strb
  );
    logic [XLEN_MAX-1:0] res;
    res = oldVal;
    for (int i = 0; i < int'(STRB_MAX); i++) begin
      if (strb[i]) res[8*i +: 8] = newVal[8*i +: 8];
    end
    return res;
  endfunction

  function automatic int unsigned popcount_w(input logic [NREGS_MAX-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < int'(NREGS_MAX); i++) begin
      cnt += 32'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Operand read, writeback and busy-issue bus between control and the register file.
interface regfile_sb_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned SW = XLEN / 8;
  localparam int unsigned CW = $clog2(NREGS + 1);

  logic [AW-1:0]   readReg1;
  logic [AW-1:0]   readReg2;
  logic [XLEN-1:0] readData1;
  logic [XLEN-1:0] readData2;
  logic            regWrite;
  logic [AW-1:0]   writeReg;
  logic [XLEN-1:0] writeData;
  logic [SW-1:0]   writeStrb;
  logic            busySet;
  logic [AW-1:0]   busyReg;
  logic            readBusy1;
  logic            readBusy2;
  logic [CW-1:0]   busyCount;

  modport master (
    output readReg1, readReg2, regWrite, writeReg, writeData, writeStrb, busySet, busyReg,
    input  readData1, readData2, readBusy1, readBusy2, busyCount
  );

  modport slave (
    input  readReg1, readReg2, regWrite, writeReg, writeData, writeStrb, busySet, busyReg,
    output readData1, readData2, readBusy1, readBusy2, busyCount
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-writeback tracking with an incrementally maintained busy count.
// With REGFILE_BYPASS_EN, a register being written this cycle reads as not busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       busySet,
  input  logic [$clog2(NREGS)-1:0]   busyReg,
  input  logic                       regWrite,
  input  logic [$clog2(NREGS)-1:0]   writeReg,
  input  logic [$clog2(NREGS)-1:0]   readReg1,
  input  logic [$clog2(NREGS)-1:0]   readReg2,
  output logic                       readBusy1,
  output logic                       readBusy2,
  output logic [$clog2(NREGS+1)-1:0] busyCount
);
  localparam int unsigned AW       = $clog2(NREGS);
  localparam int unsigned CW       = $clog2(NREGS + 1);
  localparam bit          HAS_ZERO = (ZERO_REG != 0);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busyNext;
  logic [CW-1:0]    countNext;
  logic             setEff;
  logic             clearEff;
  logic             setOk;

  // Clear on writeback first so a same-register issue in the same cycle wins.
  always_comb begin
    busyNext = busy;
    setOk    = busySet && !(HAS_ZERO && (busyReg == AW'(0)));
    if (regWrite) busyNext[writeReg] = 1'b0;
    if (setOk)    busyNext[busyReg]  = 1'b1;
    if (HAS_ZERO) busyNext[0]        = 1'b0;
  end

  // Count tracks only real transitions of the busy vector.
  always_comb begin
    countNext = busyCount;
    setEff    = setOk && !busy[busyReg];
    clearEff  = regWrite && busy[writeReg] && !(setOk && (busyReg == writeReg));
    if (setEff && !clearEff && (busyCount != CW'(NREGS))) begin
      countNext = busyCount + CW'(1);
    end else if (clearEff && !setEff && (busyCount != CW'(0))) begin
      countNext = busyCount - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= '0;
      busyCount <= '0;
    end else begin
      busy      <= busyNext;
      busyCount <= countNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (32'(busyCount) == popcount_w(NREGS_MAX'(busy)))
        else $error("busyCount %0d disagrees with busy vector", busyCount);
    end
  end

  always_comb begin
    readBusy1 = busy[readReg1];
    readBusy2 = busy[readReg2];
`ifdef REGFILE_BYPASS_EN
    if (regWrite && (writeReg == readReg1) && !(HAS_ZERO && (writeReg == AW'(0)))) begin
      readBusy1 = 1'b0;
    end
    if (regWrite && (writeReg == readReg2) && !(HAS_ZERO && (writeReg == AW'(0)))) begin
      readBusy2 = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with byte strobes, hardwired x0 and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward the write-merged value to same-cycle reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave rf
);
  localparam int unsigned AW       = $clog2(NREGS);
  localparam bit          HAS_ZERO = (ZERO_REG != 0);

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] mergedWr;
  logic            wrEn;
  logic [XLEN-1:0] rdVal1;
  logic [XLEN-1:0] rdVal2;

  // Merged word feeds both the array update and the optional bypass.
  always_comb begin
    mergedWr = XLEN'(strb_merge(XLEN_MAX'(regs[rf.writeReg]), XLEN_MAX'(rf.writeData),
                                STRB_MAX'(rf.writeStrb)));
    wrEn     = rf.regWrite && !(HAS_ZERO && (rf.writeReg == AW'(0)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wrEn) begin
      regs[rf.writeReg] <= mergedWr;
    end
  end

  always_comb begin
    rdVal1 = regs[rf.readReg1];
    rdVal2 = regs[rf.readReg2];
    if (HAS_ZERO && (rf.readReg1 == AW'(0))) rdVal1 = '0;
    if (HAS_ZERO && (rf.readReg2 == AW'(0))) rdVal2 = '0;
`ifdef REGFILE_BYPASS_EN
    if (wrEn && (rf.writeReg == rf.readReg1)) rdVal1 = mergedWr;
    if (wrEn && (rf.writeReg == rf.readReg2)) rdVal2 = mergedWr;
`endif
  end

  always_comb begin
    rf.readData1 = rdVal1;
    rf.readData2 = rdVal2;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .busySet   (rf.busySet),
    .busyReg   (rf.busyReg),
    .regWrite  (rf.regWrite),
    .writeReg  (rf.writeReg),
    .readReg1  (rf.readReg1),
    .readReg2  (rf.readReg2),
    .readBusy1 (rf.readBusy1),
    .readBusy2 (rf.readBusy2),
    .busyCount (rf.busyCount)
  );

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file for the multicycle RISC-V core; next generation of the fixed 32x32 two-read, one-write register file.
- Adds configurable width and depth, a hardwired-zero x0, byte-strobed writes, and a per-register busy scoreboard.
- The scoreboard lets the control FSM stall on operands whose multicycle writeback is still pending.
- Sits between the decode/control stage and the ALU operand muxes.

Parameters:
- XLEN, 32, data width in bits; must be a multiple of 8.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width; derived, do not override.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- readReg1  in  AW  read port 1 address.
- readReg2  in  AW  read port 2 address.
- readData1  out  XLEN  read port 1 data; combinational.
- readData2  out  XLEN  read port 2 data; combinational.
- regWrite  in  1  write enable.
- writeReg  in  AW  write address.
- writeData  in  XLEN  write data.
- writeStrb  in  XLEN/8  byte enables; bit i covers writeData[8i+7:8i].
- busySet  in  1  marks busyReg as pending (issued by control at instruction issue).
- busyReg  in  AW  register to mark busy.
- readBusy1  out  1  busy bit of readReg1; combinational.
- readBusy2  out  1  busy bit of readReg2; combinational.
- busyCount  out  $clog2(NREGS+1)  number of busy registers; registered.

Behaviour:
- Reset: on a rising edge with reset=1, all registers clear to 0, all busy bits clear, and busyCount goes to 0.
  - After that edge, readData1/2 = 0 and readBusy1/2 = 0.
  - Reset overrides regWrite and busySet in the same cycle.
- Read path: asynchronous. readDataN = regs[readRegN].
  - If ZERO_REG=1 and readRegN=0, readDataN = 0.
- Write path:
  - At a rising edge with regWrite=1, each byte i of regs[writeReg] with writeStrb[i]=1 takes writeData byte i; other bytes hold.
  - With ZERO_REG=1, writes to register 0 are dropped.
  - Write latency: one edge; the new value is visible on readData at the next cycle.
- Scoreboard:
  - busySet=1 sets busy[busyReg] at the edge.
  - regWrite=1 clears busy[writeReg] at the edge, regardless of writeStrb.
  - Set and clear on the same register in the same cycle: set wins (back-to-back issue).
  - Set and clear on different registers in the same cycle: both apply.
  - busySet on an already-busy register: no change.
  - With ZERO_REG=1, register 0 is never busy; busySet to 0 is ignored.
- busyCount:
  - Updated the same edge as the busy bits; equals the popcount of the new busy vector.
  - Implement as an incremental +1/-1/0 update, saturating in range 0..NREGS.
- Readback during a write (macro absent): readDataN shows the old value in the write cycle.
- Same-cycle hazard on read ports: readBusyN reflects the pre-edge busy state.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - readDataN returns the write-merged value when regWrite=1, writeReg=readRegN, and the register is not the hardwired zero. Write-merged value = writeData bytes where writeStrb=1, old bytes elsewhere.
  - readBusyN is forced to 0 under the same condition.
  - Lets a single-cycle writeback feed the same-cycle operand read.
- Undefined: no forwarding; behaviour as in Behaviour.

Decomposition:
- Package regfile_pkg holds:
  - localparam defaults XLEN_DEF=32, NREGS_DEF=32;
  - function strb_merge(old, new, strb), used by both the write and bypass paths;
  - function popcount_w for checking busyCount.
- One sub-module, regfile_scoreboard: busy vector, set/clear priority, busyCount, and the readBusy1/2 lookups.
- The storage array and read muxes stay in regfile_sb.

Test Plan:
- Reset, then write 200 to x2 and 10 to x5 with strb=0xF; read readReg1=2, readReg2=5 -> readData1=200, readData2=10.
- Write 0xDEADBEEF to x0 -> readData1=0 for readReg1=0. Write x7=0x11223344, then writeData=0xAABBCCDD with strb=0b0101 -> x7 reads 0x11BB33DD.
- busySet on x3 and x9 -> busyCount=2, readBusy1=1 for readReg1=3. Then regWrite x3 with busySet x3 in the same cycle -> x3 stays busy, busyCount=2.
- regWrite x9 while busySet x4 -> x9 clear, x4 busy, busyCount=2. busySet x0 -> busyCount unchanged.
- With x2=200 and x5 busy, assert reset for one edge -> readData1=readData2=0, busyCount=0, readBusy1/2=0. Deassert, read x2 -> 0.
- With REGFILE_BYPASS_EN: regWrite x6=55 while readReg2=6 -> readData2=55 in the same cycle and readBusy2=0. Without the macro, readData2 = old value, then 55 next cycle.
